// File: rtl/dmem_store_buffer.sv
// Data-memory responder: posted store buffer, 1-cycle loads with byte forwarding.
// Optional DMEM_ALIGN_CHECK_EN adds mem_d_err and drops misaligned accesses.
module dmem_store_buffer #(
  parameter int ADDR_W   = 12,
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_d_re,
  input  logic        mem_d_we,
  input  logic [31:0] mem_d_wa,
  input  logic [31:0] mem_d_wd,
  input  logic [3:0]  mem_d_wdbe,
  output logic [31:0] mem_d_rd,
  output logic        mem_d_rvalid,
  output logic        mem_d_stall,
  output logic        mem_d_idle
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        mem_d_err
`endif
);

  localparam int PW = $clog2(SB_DEPTH);

  logic [PW:0]       count;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [ADDR_W-1:0] sb_idx  [SB_DEPTH];
  logic [31:0]       sb_data [SB_DEPTH];
  logic [3:0]        sb_be   [SB_DEPTH];
  logic [31:0]       mem     [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic [31:0]       st_wd;
  logic [3:0]        st_be;
  logic              ld_bad;
  logic              st_bad;
  logic              load_go;
  logic              acc;
  logic              drain;
  logic              unused;

  assign idx    = mem_d_wa[ADDR_W+1:2];
  assign unused = ^{mem_d_wa[31:ADDR_W+2], mem_d_wa[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0]  off;
  logic [7:0]  be_sh;
  logic [63:0] wd_sh;
  logic        err_q;

  assign off    = mem_d_wa[1:0];
  assign be_sh  = {4'b0, mem_d_wdbe} << off;
  assign wd_sh  = {32'b0, mem_d_wd} << {off, 3'b0};
  assign st_be  = be_sh[3:0];
  assign st_wd  = wd_sh[31:0];
  assign ld_bad = mem_d_re & ~mem_d_we & (off != 2'b00);
  assign st_bad = mem_d_we & (be_sh[7:4] != 4'b0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= ld_bad | st_bad;
  end

  assign mem_d_err = err_q;
`else
  assign st_be  = mem_d_wdbe;
  assign st_wd  = mem_d_wd;
  assign ld_bad = 1'b0;
  assign st_bad = 1'b0;
`endif

  assign mem_d_stall = (count == (PW+1)'(SB_DEPTH));
  assign mem_d_idle  = (count == '0);

  assign load_go = mem_d_re & ~mem_d_we & ~ld_bad;
  assign acc     = mem_d_we & ~mem_d_stall & ~st_bad;
  assign drain   = ~mem_d_re & ~mem_d_idle;

  // Youngest matching entry wins per lane: later offsets overwrite earlier ones.
  logic [31:0]   fwd_d;
  logic [3:0]    fwd_m;
  logic [PW-1:0] pos;

  always_comb begin
    fwd_d = '0;
    fwd_m = '0;
    pos   = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      pos = head + PW'(k);
      if (((PW+1)'(k) < count) && (sb_idx[pos] == idx)) begin
        for (int l = 0; l < 4; l++) begin
          if (sb_be[pos][l]) begin
            fwd_d[8*l +: 8] = sb_data[pos][8*l +: 8];
            fwd_m[l]        = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      head         <= '0;
      tail         <= '0;
      mem_d_rvalid <= 1'b0;
    end else begin
      mem_d_rvalid <= load_go;
      if (acc)   tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      unique case ({acc, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [31:0] mem_q;
  logic [31:0] fwd_d_q;
  logic [3:0]  fwd_m_q;

  always_ff @(posedge clk) begin
    if (acc) begin
      sb_idx[tail]  <= idx;
      sb_data[tail] <= st_wd;
      sb_be[tail]   <= st_be;
    end
    if (drain) begin
      for (int l = 0; l < 4; l++) begin
        if (sb_be[head][l])
          mem[sb_idx[head]][8*l +: 8] <= sb_data[head][8*l +: 8];
      end
    end
    if (load_go) begin
      mem_q   <= mem[idx];
      fwd_d_q <= fwd_d;
      fwd_m_q <= fwd_m;
    end
  end

  logic [31:0] rd_m;

  always_comb begin
    rd_m = '0;
    for (int l = 0; l < 4; l++)
      rd_m[8*l +: 8] = fwd_m_q[l] ? fwd_d_q[8*l +: 8] : mem_q[8*l +: 8];
  end

  assign mem_d_rd = mem_d_rvalid ? rd_m : '0;

endmodule
